// File: rtl/hpm_slv_pkg.sv
// Shared AXI encodings and FSM state type for the HPM0 register slave.
package hpm_slv_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] BURST_WRAP  = 2'b10;

    typedef enum logic [1:0] {
        IDLE,
        WDATA,
        WRESP,
        RDATA
    } state_t;

endpackage

// File: rtl/hpm_slv_regfile.sv
// REG_COUNT x DATA_W register storage: byte-strobe write, combinational read, ctrl tap.
// Define HPM_SLV_TIMESTAMP_EN to turn the top word into a read-only 64-bit cycle counter.
module hpm_slv_regfile #(
    parameter int DATA_W    = 128,
    parameter int REG_COUNT = 16,
    parameter int CTRL_W    = 8,
    localparam int IDX_W    = $clog2(REG_COUNT)
) (
    input  logic                aclk,
    input  logic                arst,
    input  logic                we,
    input  logic [IDX_W-1:0]    widx,
    input  logic [DATA_W-1:0]   wdata,
    input  logic [DATA_W/8-1:0] wstrb,
    input  logic [IDX_W-1:0]    ridx,
    output logic [DATA_W-1:0]   rdata,
    output logic [CTRL_W-1:0]   ctrl_out
);

    logic [REG_COUNT-1:0][DATA_W-1:0] regs;
    logic                             writable;

`ifdef HPM_SLV_TIMESTAMP_EN
    localparam logic [IDX_W-1:0] TS_IDX = IDX_W'(REG_COUNT - 1);
    logic [63:0] ts;

    always_ff @(posedge aclk or posedge arst) begin
        if (arst) ts <= '0;
        else      ts <= ts + 64'd1;
    end

    // Writes aimed at the timestamp word are silently discarded.
    assign writable = (widx != TS_IDX);
    assign rdata    = (ridx == TS_IDX) ? {{(DATA_W-64){1'b0}}, ts} : regs[ridx];
`else
    assign writable = 1'b1;
    assign rdata    = regs[ridx];
`endif

    always_ff @(posedge aclk or posedge arst) begin
        if (arst) begin
            regs <= '0;
        end else if (we && writable) begin
            for (int b = 0; b < DATA_W/8; b++) begin
                if (wstrb[b]) regs[widx][b*8 +: 8] <= wdata[b*8 +: 8];
            end
        end
    end

    assign ctrl_out = regs[0][CTRL_W-1:0];

endmodule

// File: rtl/hpm_axi_reg_slave.sv
// AXI4 register-bank slave for the ZynqMP HPM0 FPD port; one transaction at a time.
// Optional timestamp word via HPM_SLV_TIMESTAMP_EN (see hpm_slv_regfile).
module hpm_axi_reg_slave
    import hpm_slv_pkg::*;
#(
    parameter int ID_W      = 16,
    parameter int ADDR_W    = 40,
    parameter int DATA_W    = 128,
    parameter int REG_COUNT = 16,
    parameter int CTRL_W    = 8
) (
    input  logic                aclk,
    input  logic                arst,
    input  logic [ID_W-1:0]     awid,
    input  logic [ADDR_W-1:0]   awaddr,
    input  logic [7:0]          awlen,
    input  logic [1:0]          awburst,
    input  logic                awvalid,
    output logic                awready,
    input  logic [DATA_W-1:0]   wdata,
    input  logic [DATA_W/8-1:0] wstrb,
    input  logic                wlast,
    input  logic                wvalid,
    output logic                wready,
    output logic [ID_W-1:0]     bid,
    output logic [1:0]          bresp,
    output logic                bvalid,
    input  logic                bready,
    input  logic [ID_W-1:0]     arid,
    input  logic [ADDR_W-1:0]   araddr,
    input  logic [7:0]          arlen,
    input  logic [1:0]          arburst,
    input  logic                arvalid,
    output logic                arready,
    output logic [ID_W-1:0]     rid,
    output logic [DATA_W-1:0]   rdata,
    output logic [1:0]          rresp,
    output logic                rlast,
    output logic                rvalid,
    input  logic                rready,
    output logic [CTRL_W-1:0]   ctrl_out
);

    localparam int LSB   = $clog2(DATA_W/8);
    localparam int IDX_W = $clog2(REG_COUNT);
    localparam int WA_W  = ADDR_W - LSB;

    state_t              state;
    logic                rr_pref;
    logic                err;
    logic [ID_W-1:0]     id_q;
    logic [WA_W-1:0]     wa_q;
    logic [7:0]          len_q;
    logic [7:0]          cnt_q;
    logic [1:0]          burst_q;

    logic [IDX_W-1:0]    idx;
    logic                oor;
    logic                last_beat;
    logic                aw_hs;
    logic                ar_hs;
    logic                w_hs;
    logic                r_hs;
    logic [WA_W-1:0]     wa_next;
    logic [DATA_W-1:0]   reg_rdata;

    // Sub-word address bits only select bytes within a word, which strobes already do.
    logic                unused_addr_lsbs;
    assign unused_addr_lsbs = ^{awaddr[LSB-1:0], araddr[LSB-1:0]};

    assign idx       = wa_q[IDX_W-1:0];
    assign oor       = |wa_q[WA_W-1:IDX_W];
    assign last_beat = (cnt_q == len_q);
    assign wa_next   = (burst_q == BURST_FIXED) ? wa_q : wa_q + WA_W'(1);

    // Round-robin arbitration: rr_pref=0 favours AW, rr_pref=1 favours AR.
    assign awready = (state == IDLE) && awvalid && (!arvalid || !rr_pref);
    assign arready = (state == IDLE) && arvalid && (!awvalid || rr_pref);
    assign aw_hs   = awvalid && awready;
    assign ar_hs   = arvalid && arready;

    assign wready  = (state == WDATA);
    assign w_hs    = wvalid && wready;

    assign bvalid  = (state == WRESP);
    assign bid     = id_q;
    assign bresp   = (bvalid && err) ? RESP_SLVERR : RESP_OKAY;

    assign rvalid  = (state == RDATA);
    assign r_hs    = rvalid && rready;
    assign rid     = rvalid ? id_q : '0;
    assign rdata   = (rvalid && !oor) ? reg_rdata : '0;
    assign rresp   = (rvalid && oor) ? RESP_SLVERR : RESP_OKAY;
    assign rlast   = rvalid && last_beat;

    hpm_slv_regfile #(
        .DATA_W    (DATA_W),
        .REG_COUNT (REG_COUNT),
        .CTRL_W    (CTRL_W)
    ) u_regfile (
        .aclk     (aclk),
        .arst     (arst),
        .we       (w_hs && !oor),
        .widx     (idx),
        .wdata    (wdata),
        .wstrb    (wstrb),
        .ridx     (idx),
        .rdata    (reg_rdata),
        .ctrl_out (ctrl_out)
    );

    always_ff @(posedge aclk or posedge arst) begin
        if (arst) begin
            state   <= IDLE;
            rr_pref <= 1'b0;
            err     <= 1'b0;
            id_q    <= '0;
            wa_q    <= '0;
            len_q   <= '0;
            cnt_q   <= '0;
            burst_q <= BURST_FIXED;
        end else begin
            case (state)
                IDLE: begin
                    if (aw_hs) begin
                        id_q    <= awid;
                        wa_q    <= awaddr[ADDR_W-1:LSB];
                        len_q   <= awlen;
                        burst_q <= awburst;
                        cnt_q   <= '0;
                        rr_pref <= 1'b1;
                        state   <= WDATA;
                    end else if (ar_hs) begin
                        id_q    <= arid;
                        wa_q    <= araddr[ADDR_W-1:LSB];
                        len_q   <= arlen;
                        burst_q <= arburst;
                        cnt_q   <= '0;
                        rr_pref <= 1'b0;
                        state   <= RDATA;
                    end
                end
                WDATA: begin
                    if (w_hs) begin
                        // Burst length comes from awlen; wlast is only checked.
                        if (oor || (wlast != last_beat)) err <= 1'b1;
                        cnt_q <= cnt_q + 8'd1;
                        wa_q  <= wa_next;
                        if (last_beat) state <= WRESP;
                    end
                end
                WRESP: begin
                    if (bready) begin
                        err   <= 1'b0;
                        state <= IDLE;
                    end
                end
                RDATA: begin
                    if (r_hs) begin
                        cnt_q <= cnt_q + 8'd1;
                        wa_q  <= wa_next;
                        if (last_beat) state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_hpm_axi_reg_slave.sv
// Directed plus randomized bench for hpm_axi_reg_slave against a word-array reference model.
module tb_hpm_axi_reg_slave;

    logic          aclk;
    logic          arst;
    logic [15:0]   awid;
    logic [39:0]   awaddr;
    logic [7:0]    awlen;
    logic [1:0]    awburst;
    logic          awvalid;
    logic          awready;
    logic [127:0]  wdata;
    logic [15:0]   wstrb;
    logic          wlast;
    logic          wvalid;
    logic          wready;
    logic [15:0]   bid;
    logic [1:0]    bresp;
    logic          bvalid;
    logic          bready;
    logic [15:0]   arid;
    logic [39:0]   araddr;
    logic [7:0]    arlen;
    logic [1:0]    arburst;
    logic          arvalid;
    logic          arready;
    logic [15:0]   rid;
    logic [127:0]  rdata;
    logic [1:0]    rresp;
    logic          rlast;
    logic          rvalid;
    logic          rready;
    logic [7:0]    ctrl_out;

    hpm_axi_reg_slave dut (
        .aclk(aclk), .arst(arst),
        .awid(awid), .awaddr(awaddr), .awlen(awlen), .awburst(awburst),
        .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
        .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready),
        .arid(arid), .araddr(araddr), .arlen(arlen), .arburst(arburst),
        .arvalid(arvalid), .arready(arready),
        .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
        .ctrl_out(ctrl_out)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    int            vectors;
    int            miscompares;
    logic [127:0]  model_mem [16];
    logic [127:0]  wbuf [256];
    logic [15:0]   sbuf [256];
    logic [15:0]   cur_id;
    logic [39:0]   cur_addr;
    logic [7:0]    cur_len;
    logic [1:0]    cur_burst;
    logic          cur_err;
    logic [63:0]   ts_val;
    logic [3:0]    rpat;
    int            rpat_i;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [39:0] beat_addr(input logic [39:0] base, input logic [1:0] burst, input int i);
        return (burst == 2'b00) ? base : base + 40'(i) * 40'd16;
    endfunction

    function automatic logic in_range(input logic [39:0] a);
        return (a[39:8] == 32'd0);
    endfunction

    function automatic logic writable(input logic [3:0] idx);
`ifdef HPM_SLV_TIMESTAMP_EN
        return (idx != 4'd15);
`else
        return (idx == idx);
`endif
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 16; k++) model_mem[k] = '0;
    endtask

    task automatic set_cur(input logic [15:0] id, input logic [39:0] addr, input logic [7:0] len, input logic [1:0] burst);
        cur_id = id; cur_addr = addr; cur_len = len; cur_burst = burst; cur_err = 1'b0;
    endtask

    task automatic aw_phase(input logic [15:0] id, input logic [39:0] addr, input logic [7:0] len, input logic [1:0] burst);
        int n;
        set_cur(id, addr, len, burst);
        awid = id; awaddr = addr; awlen = len; awburst = burst; awvalid = 1'b1;
        #1;
        n = 0;
        while (!awready && n < 100) begin @(negedge aclk); #1; n++; end
        check("awready", awready, 1'b1);
        @(negedge aclk);
        awvalid = 1'b0;
    endtask

    task automatic ar_phase(input logic [15:0] id, input logic [39:0] addr, input logic [7:0] len, input logic [1:0] burst);
        int n;
        set_cur(id, addr, len, burst);
        arid = id; araddr = addr; arlen = len; arburst = burst; arvalid = 1'b1;
        #1;
        n = 0;
        while (!arready && n < 100) begin @(negedge aclk); #1; n++; end
        check("arready", arready, 1'b1);
        @(negedge aclk);
        arvalid = 1'b0;
    endtask

    // bad_beat flips wlast on that beat (-1: well-formed burst).
    task automatic w_phase(input int bad_beat);
        int n;
        logic [39:0] a;
        for (int i = 0; i <= int'(cur_len); i++) begin
            a = beat_addr(cur_addr, cur_burst, i);
            wdata = wbuf[i]; wstrb = sbuf[i];
            wlast = (i == int'(cur_len)) != (i == bad_beat);
            wvalid = 1'b1;
            #1;
            n = 0;
            while (!wready && n < 100) begin @(negedge aclk); #1; n++; end
            check("wready", wready, 1'b1);
            if (!in_range(a)) cur_err = 1'b1;
            else if (writable(a[7:4])) begin
                for (int b = 0; b < 16; b++)
                    if (sbuf[i][b]) model_mem[a[7:4]][b*8 +: 8] = wbuf[i][b*8 +: 8];
            end
            if (wlast != (i == int'(cur_len))) cur_err = 1'b1;
            @(negedge aclk);
        end
        wvalid = 1'b0; wlast = 1'b0;
        check("ctrl_out", ctrl_out, model_mem[0][7:0]);
    endtask

    task automatic b_phase();
        int n;
        bready = 1'b1;
        #1;
        n = 0;
        while (!bvalid && n < 100) begin @(negedge aclk); #1; n++; end
        check("bvalid", bvalid, 1'b1);
        check("bid", bid, cur_id);
        check("bresp", bresp, cur_err ? 2'b10 : 2'b00);
        @(negedge aclk);
        bready = 1'b0;
        #1;
        check("bvalid_drop", bvalid, 1'b0);
    endtask

    // mode 0: rready high, 1: random rready, 2: rready follows rpat; abort_beat asserts arst.
    task automatic r_phase(input int mode, input int abort_beat);
        int stalls;
        logic [39:0]  a;
        logic [127:0] exp_d;
        for (int i = 0; i <= int'(cur_len); i++) begin
            a = beat_addr(cur_addr, cur_burst, i);
            exp_d = in_range(a) ? model_mem[a[7:4]] : '0;
            stalls = 0;
            do begin
                if (mode == 0)      rready = 1'b1;
                else if (mode == 1) rready = (stalls > 6) ? 1'b1 : 1'($urandom_range(0, 1));
                else begin rready = rpat[rpat_i % 4]; rpat_i++; end
                if (i == abort_beat) begin
                    arst = 1'b1;
                    #1;
                    check("abort_rvalid", rvalid, 1'b0);
                    check("abort_ctrl_out", ctrl_out, 8'h00);
                    check("abort_bvalid", bvalid, 1'b0);
                    model_reset();
                    @(negedge aclk);
                    arst = 1'b0; rready = 1'b0;
                    return;
                end
                #1;
                check("rvalid", rvalid, 1'b1);
`ifdef HPM_SLV_TIMESTAMP_EN
                if (in_range(a) && a[7:4] == 4'd15) begin
                    ts_val = rdata[63:0];
                    check("ts_upper", rdata[127:64], 64'd0);
                end else
`endif
                check("rdata", rdata, exp_d);
                check("rresp", rresp, in_range(a) ? 2'b00 : 2'b10);
                check("rid", rid, cur_id);
                check("rlast", rlast, i == int'(cur_len));
                stalls++;
                if (stalls > 40) begin
                    check("r_stall_bound", 1'b0, 1'b1);
                    rready = 1'b1;
                end
                @(negedge aclk);
            end while (!rready);
        end
        rready = 1'b0;
        #1;
        check("rvalid_drop", rvalid, 1'b0);
    endtask

    task automatic fill_random(input int len);
        for (int i = 0; i <= len; i++) begin
            wbuf[i] = {$urandom, $urandom, $urandom, $urandom};
            sbuf[i] = ($urandom_range(0, 2) == 0) ? 16'hFFFF : 16'($urandom);
        end
    endtask

    initial begin
        logic [63:0]  ts_first;
        logic [7:0]   len;
        logic [39:0]  addr;
        int           bad;
        vectors = 0; miscompares = 0; rpat_i = 0; ts_val = '0;
        rpat = 4'b1001;
        arst = 1'b1;
        awid = '0; awaddr = '0; awlen = '0; awburst = '0; awvalid = 1'b0;
        wdata = '0; wstrb = '0; wlast = 1'b0; wvalid = 1'b0; bready = 1'b0;
        arid = '0; araddr = '0; arlen = '0; arburst = '0; arvalid = 1'b0; rready = 1'b0;
        model_reset();
        repeat (3) @(negedge aclk);
        arst = 1'b0;
        #1;
        check("rst_awready", awready, 1'b0);
        check("rst_arready", arready, 1'b0);
        check("rst_wready", wready, 1'b0);
        check("rst_bvalid", bvalid, 1'b0);
        check("rst_rvalid", rvalid, 1'b0);
        check("rst_rdata", rdata, 128'd0);
        check("rst_rlast", rlast, 1'b0);
        check("rst_bresp", bresp, 2'b00);
        check("rst_ctrl_out", ctrl_out, 8'h00);

        // Simultaneous AW/AR from reset: write wins, then read wins.
        @(negedge aclk);
        awid = 16'h0001; awaddr = 40'h30; awlen = 8'd0; awburst = 2'b01;
        arid = 16'h0002; araddr = 40'h30; arlen = 8'd0; arburst = 2'b01;
        awvalid = 1'b1; arvalid = 1'b1;
        #1;
        check("arb1_awready", awready, 1'b1);
        check("arb1_arready", arready, 1'b0);
        set_cur(16'h0001, 40'h30, 8'd0, 2'b01);
        @(negedge aclk);
        awvalid = 1'b0; arvalid = 1'b0;
        wbuf[0] = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210; sbuf[0] = 16'hFFFF;
        w_phase(-1);
        b_phase();
        awvalid = 1'b1; arvalid = 1'b1;
        #1;
        check("arb2_awready", awready, 1'b0);
        check("arb2_arready", arready, 1'b1);
        set_cur(16'h0002, 40'h30, 8'd0, 2'b01);
        @(negedge aclk);
        awvalid = 1'b0; arvalid = 1'b0;
        r_phase(0, -1);

        // LED word: single write to word 0.
        wbuf[0] = 128'hA5; sbuf[0] = 16'hFFFF;
        aw_phase(16'h0012, 40'h0, 8'd0, 2'b01);
        w_phase(-1);
        check("led_ctrl", ctrl_out, 8'hA5);
        b_phase();

        // INCR 4-beat write and read back.
        fill_random(3);
        aw_phase(16'h0BEE, 40'h20, 8'd3, 2'b01);
        w_phase(-1);
        b_phase();
        ar_phase(16'h0C0D, 40'h20, 8'd3, 2'b01);
        r_phase(0, -1);

        // Out-of-range read and write.
        ar_phase(16'h0005, 40'h100, 8'd0, 2'b01);
        r_phase(0, -1);
        fill_random(0);
        aw_phase(16'h0006, 40'h100, 8'd0, 2'b01);
        w_phase(-1);
        b_phase();

        // Stalled read with rready 1,0,0,1.
        rpat_i = 0;
        ar_phase(16'h0007, 40'h20, 8'd3, 2'b01);
        r_phase(2, -1);

        // Malformed wlast: early and missing.
        fill_random(2);
        aw_phase(16'h0008, 40'h40, 8'd2, 2'b01);
        w_phase(0);
        b_phase();
        fill_random(2);
        aw_phase(16'h0009, 40'h40, 8'd2, 2'b00);
        w_phase(2);
        b_phase();

        // Randomized traffic.
        for (int k = 0; k < 24; k++) begin
            len  = 8'($urandom_range(0, 5));
            addr = ($urandom_range(0, 7) == 0) ? 40'h100 + 40'($urandom_range(0, 15)) * 16
                                               : 40'($urandom_range(0, 255));
            bad  = ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, int'(len))) : -1;
            fill_random(int'(len));
            aw_phase(16'($urandom), addr, len, 2'($urandom_range(0, 2)));
            w_phase(bad);
            b_phase();
            len  = 8'($urandom_range(0, 6));
            addr = ($urandom_range(0, 7) == 0) ? 40'h1F0 : 40'($urandom_range(0, 255));
            ar_phase(16'($urandom), addr, len, 2'($urandom_range(0, 2)));
            r_phase(1, -1);
        end

        // Reset during beat 2 of an 8-beat read, then a clean read.
        wbuf[0] = 128'h5A; sbuf[0] = 16'h0001;
        aw_phase(16'h0010, 40'h0, 8'd0, 2'b01);
        w_phase(-1);
        b_phase();
        ar_phase(16'h0011, 40'h0, 8'd7, 2'b01);
        r_phase(0, 2);
        ar_phase(16'h0013, 40'h0, 8'd1, 2'b01);
        r_phase(0, -1);

`ifdef HPM_SLV_TIMESTAMP_EN
        ar_phase(16'h0014, 40'hF0, 8'd0, 2'b01);
        r_phase(0, -1);
        ts_first = ts_val;
        repeat (5) @(negedge aclk);
        ar_phase(16'h0015, 40'hF0, 8'd0, 2'b01);
        r_phase(0, -1);
        check("ts_increasing", ts_val > ts_first, 1'b1);
`else
        ts_first = '0;
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/hpm_axi_reg_slave.md
Name: hpm_axi_reg_slave

Overview:
- AXI4 slave register bank on the PL side of the Zynq UltraScale+ MAXIGP0 (HPM0 FPD) master port.
- Consumes the PS master's AW/W/B/AR/R channels in place of the current tie-offs, so PS software can read and write PL control words.
- Low bits of word 0 drive PL control outputs, e.g. the board LED.
- Serves one transaction at a time; supports FIXED and INCR bursts of up to 256 beats.

Parameters:
- ID_W, 16, AXI ID width (matches maxigp0 bid/rid)
- ADDR_W, 40, AXI address width
- DATA_W, 128, data width; one register word = DATA_W bits
- REG_COUNT, 16, number of register words; power of two, ≥2
- CTRL_W, 8, width of ctrl_out taken from word 0 bits [CTRL_W-1:0]

Ports:
- aclk in 1: single clock (driven from pl_clk0, same net as maxihpm0_fpd_aclk)
- arst in 1: asynchronous, active-high reset
- awid/awaddr/awlen/awburst in ID_W/ADDR_W/8/2: write address
- awvalid in 1, awready out 1
- wdata/wstrb/wlast in DATA_W/DATA_W/8/1: write data
- wvalid in 1, wready out 1
- bid/bresp out ID_W/2: write response
- bvalid out 1, bready in 1
- arid/araddr/arlen/arburst in ID_W/ADDR_W/8/2: read address
- arvalid in 1, arready out 1
- rid/rdata/rresp/rlast out ID_W/DATA_W/2/1: read data
- rvalid out 1, rready in 1
- ctrl_out out CTRL_W: word 0 [CTRL_W-1:0]

Behaviour:
- Reset (async assert, sync deassert expected): state IDLE; all registers 0; awready, wready, bvalid, arready, rvalid = 0; bresp, rresp, rid, bid, rdata = 0; rlast = 0; ctrl_out = 0; rr_pref = 0 (write first).
- Word index = addr[IDX_W+LSB-1:LSB], with LSB = log2(DATA_W/8). A beat is out of range when addr bits above the index are nonzero.
- FSM states: IDLE, WDATA, WRESP, RDATA.
- IDLE:
  - awready = awvalid && (!arvalid || !rr_pref); arready = arvalid && (!awvalid || rr_pref). Both are combinational from state and the valids.
  - AW handshake → latch id, addr, len, burst; go to WDATA; rr_pref←1.
  - AR handshake → latch the same fields; go to RDATA; rr_pref←0. rvalid rises the next cycle with beat 0.
- WDATA:
  - wready = 1.
  - Each accepted beat writes the byte lanes enabled by wstrb into the current word, on the same edge.
  - Out-of-range beats are dropped and set err.
  - Beat counter advances; INCR adds DATA_W/8 to the address; FIXED holds it; WRAP is treated as INCR.
  - Termination is by counter == len, not by wlast. wlast on the wrong beat, or missing on the final beat, sets err.
  - After the final beat → WRESP.
- WRESP: bvalid = 1, bid = latched id, bresp = err ? SLVERR(2'b10) : OKAY. Hold until bready; then → IDLE and clear err.
- RDATA:
  - rdata = current word, or 0 if out of range. rresp is per beat: SLVERR if out of range, else OKAY.
  - rid = latched id; rlast = (counter == len).
  - On each rvalid&&rready, advance; the next beat is presented in the following cycle with no bubble.
  - After the last beat → IDLE; rvalid drops the cycle after.
- Read-after-write: a read of a word written in a completed prior transaction returns the new value.
- Output and handshake rules:
  - ctrl_out is registered: it updates in the cycle after the write beat.
  - Outputs stay stable while valid && !ready.
- arst mid-transaction: the transaction is abandoned, all state goes to reset values, and there is no B or R response.

Optional Feature:
- HPM_SLV_TIMESTAMP_EN defined:
  - Word REG_COUNT-1 becomes read-only: bits [63:0] are a free-running cycle counter, reset 0, wrapping at 2^64; upper bits read 0.
  - Writes to that word are ignored with OKAY.
- Undefined: word REG_COUNT-1 is an ordinary read/write register and no counter exists.

Decomposition:
- hpm_slv_pkg holds:
  - RESP_OKAY/RESP_SLVERR
  - BURST_FIXED/BURST_INCR/BURST_WRAP
  - the state_t enum {IDLE, WDATA, WRESP, RDATA}
- One sub-module, hpm_slv_regfile: REG_COUNT×DATA_W storage with byte-strobe write port, combinational read port, ctrl_out tap, and the optional timestamp word.

Test Plan:
- Single write to addr 0x0 with wdata[7:0]=0xA5, wstrb=all-ones, awid=0x0012 → bid=0x0012, bresp=OKAY, ctrl_out=0xA5 the cycle after the W beat.
- INCR write of 4 beats at 0x20 (awlen=3), then INCR read of the same range (arlen=3) → 4 rdata match; rlast only on beat 3; rid echoes arid.
- Read at 0x100 with REG_COUNT=16, LSB=4 (out of range) → rdata=0, rresp=SLVERR; a write there → bresp=SLVERR and no register changes.
- awvalid and arvalid asserted together from reset → write served first; if both are asserted together again, the read is served next (round-robin).
- Read burst with rready toggled 1,0,0,1 → rdata/rlast held stable while stalled; no beat lost or duplicated.
- Assert arst during beat 2 of an 8-beat read → rvalid=0 and ctrl_out=0 at once; the next AR completes normally. With HPM_SLV_TIMESTAMP_EN, two reads of word 15 show an increasing counter.
